// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO register pair with a shared iterative shift-add multiplier / restoring divider.
// Stalls the pipeline while an operation is in flight and pulses done on completion.
module muldiv_hilo_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mf_req,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // product accumulator; low half is dividend/quotient
  logic [WIDTH:0]       rem_q, rem_d;
  logic                 qsign_q, qsign_d, rsign_q, rsign_d, is_div_q, is_div_d;

  logic                 signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 last_iter;

  always_comb begin
    signed_op = (op == 3'd0) || (op == 3'd2);
    a_neg     = signed_op & src_a[WIDTH-1];
    b_neg     = signed_op & src_b[WIDTH-1];
    abs_a     = a_neg ? -src_a : src_a;
    abs_b     = b_neg ? -src_b : src_b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    prod_fix  = qsign_q ? -acc_q : acc_q;
    quo_fix   = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    is_div_d = is_div_q;
    if (flush) begin
      // Cancels everything, including a same-cycle start or MTHI/MTLO.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            case (op)
              3'd0, 3'd1: begin
                opnd_d   = abs_a;
                acc_d    = {{WIDTH{1'b0}}, abs_b};
                rem_d    = '0;
                qsign_d  = a_neg ^ b_neg;
                rsign_d  = a_neg;
                is_div_d = 1'b0;
                cnt_d    = '0;
                state_d  = StMul;
              end
              3'd2, 3'd3: begin
                if (src_b == '0) begin
                  done_d = 1'b1;
                end else begin
                  opnd_d   = abs_b;
                  acc_d    = {{WIDTH{1'b0}}, abs_a};
                  rem_d    = '0;
                  qsign_d  = a_neg ^ b_neg;
                  rsign_d  = a_neg;
                  is_div_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = StDiv;
                end
              end
              3'd4:    hi_d = src_a;
              3'd5:    lo_d = src_a;
              default: ;
            endcase
          end
        end
        StMul: begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            cnt_d   = '0;
            state_d = StFix;
          end
        end
        StDiv: begin
          if (!div_trial[WIDTH]) begin
            rem_d = div_trial;
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift;
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            cnt_d   = '0;
            state_d = StFix;
          end
        end
        StFix: begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      is_div_q <= is_div_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign stall = busy & (start | mf_req);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Randomized and directed bench for muldiv_hilo_ctrl against a plain-arithmetic HI/LO model.
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mf_req, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_hilo_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .mf_req (mf_req),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result of a MULT/MULTU/DIV/DIVU on the model registers.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sp, sq, sr;
    longint unsigned up;
    case (o)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      3'd2: if (b != 0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        m_hi = sr[31:0];
        m_lo = sq[31:0];
      end
      3'd3: if (b != 0) begin
        m_hi = a % b;
        m_lo = a / b;
      end
      default: ;
    endcase
  endtask

  task automatic do_muldiv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int busy_cnt, done_cnt, done_at, exp_busy;
    logic [31:0] hi_at, lo_at;
    exp_busy = (o >= 3'd2 && b == 0) ? 0 : 33;
    model_op(o, a, b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; hi_at = '0; lo_at = '0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
        hi_at = hi;
        lo_at = lo;
      end
      tick();
    end
    check($sformatf("busy_cycles op%0d", o), 64'(busy_cnt), 64'(exp_busy));
    check($sformatf("done_count op%0d", o), 64'(done_cnt), 64'd1);
    check($sformatf("done_cycle op%0d", o), 64'(done_at), 64'(exp_busy));
    check($sformatf("hi op%0d a=%h b=%h", o, a, b), {32'd0, hi_at}, {32'd0, m_hi});
    check($sformatf("lo op%0d a=%h b=%h", o, a, b), {32'd0, lo_at}, {32'd0, m_lo});
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] v);
    start = 1'b1; op = o; src_a = v; src_b = '0;
    if (o == 3'd4) m_hi = v; else m_lo = v;
    tick();
    start = 1'b0;
    check("mt_done", {63'd0, done}, 64'd0);
    check("mt_hi", {32'd0, hi}, {32'd0, m_hi});
    check("mt_lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  // Watch a few cycles after a cancelled operation: idle, no done, HI/LO held.
  task automatic expect_quiet(input string tag);
    int done_cnt;
    int busy_cnt;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      tick();
    end
    check({tag, "_done"}, 64'(done_cnt), 64'd0);
    check({tag, "_busy"}, 64'(busy_cnt), 64'd0);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    int stall_bad, waited;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; mf_req = 1'b0; flush = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    tick();

    do_muldiv(3'd0, 32'hFFFF_FFFD, 32'd7);
    do_muldiv(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_muldiv(3'd2, 32'hFFFF_FFF9, 32'd2);
    do_muldiv(3'd3, 32'd100, 32'd7);
    do_muldiv(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    do_mt(3'd4, 32'h11);
    do_mt(3'd5, 32'h22);
    do_muldiv(3'd3, 32'h1234, 32'd0);
    do_muldiv(3'd2, 32'h1234, 32'd0);

    // Ignored opcodes and flush-with-start / flush-blocks-MTHI.
    start = 1'b1; op = 3'd6; src_a = 32'hDEAD; src_b = 32'd3;
    tick();
    op = 3'd4; flush = 1'b1;
    tick();
    op = 3'd0;
    tick();
    start = 1'b0; flush = 1'b0;
    expect_quiet("ignored_and_flushed_start");

    // MTHI held off by stall while a MULT runs.
    model_op(3'd0, 32'd123, 32'hFFFF_FF00);
    start = 1'b1; op = 3'd0; src_a = 32'd123; src_b = 32'hFFFF_FF00;
    tick();
    op = 3'd4; src_a = 32'hCAFE_BABE; mf_req = 1'b1;
    stall_bad = 0; waited = 0;
    while (busy && waited < 50) begin
      if (!stall) stall_bad++;
      waited++;
      tick();
    end
    check("mthi_stall_while_busy", 64'(stall_bad), 64'd0);
    check("mthi_wait_cycles", 64'(waited), 64'd33);
    check("mthi_stall_idle", {63'd0, stall}, 64'd0);
    tick();
    start = 1'b0; mf_req = 1'b0;
    m_hi = 32'hCAFE_BABE;
    check("mthi_hi", {32'd0, hi}, {32'd0, m_hi});
    check("mthi_lo_kept", {32'd0, lo}, {32'd0, m_lo});

    // Flush during iteration 10 of a DIV.
    start = 1'b1; op = 3'd2; src_a = 32'hF000_0001; src_b = 32'd5;
    tick();
    start = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_quiet("flush_mid_div");

    // Flush coinciding with the fix-up cycle.
    start = 1'b1; op = 3'd3; src_a = 32'd999; src_b = 32'd10;
    tick();
    start = 1'b0;
    repeat (32) tick();
    check("fix_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_quiet("flush_at_fix");

    // Asynchronous reset in the middle of a MULT.
    start = 1'b1; op = 3'd1; src_a = 32'd77; src_b = 32'd88;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    do_muldiv(3'd0, 32'hFFFF_FFFD, 32'd7);

    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 9));
        1: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
        default: rb = $urandom;
      endcase
      if (k % 7 == 3) ra = 32'h8000_0000;
      do_muldiv(ro, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
